// File: rtl/collision_manager_pkg.sv
// Shared game constants and types for the collision manager and its
// bounding-box comparator: state encodings, coordinate width, screen limits.
package collision_manager_pkg;

    localparam int COORD_W  = 10;
    localparam int SUM_W    = COORD_W + 1;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        PLAYING   = 2'd0,
        HIT       = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } state_e;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SUM_W-1:0]   edge_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
    } box_t;

    typedef struct packed {
        edge_t a_l, a_t, a_r, a_b;
        edge_t b_l, b_t, b_r, b_b;
        logic  nonzero;
    } bbox_stage1_t;

    // One extra bit so a box near the coordinate limit never wraps.
    function automatic edge_t far_edge(input coord_t pos, input coord_t size);
        return {1'b0, pos} + {1'b0, size};
    endfunction

endpackage

// File: rtl/collision_manager_bbox_overlap.sv
// Two-stage pipelined axis-aligned bounding-box overlap test between two boxes.
// Stage 1 registers all box edges; stage 2 registers the combined compare.
module bbox_overlap
    import collision_manager_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  box_t box_a,
    input  box_t box_b,
    output logic overlap_q
);

    bbox_stage1_t s1_d, s1_q;
    logic         overlap_d;

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        s1_d.a_l     = {1'b0, box_a.x};
        s1_d.a_t     = {1'b0, box_a.y};
        s1_d.a_r     = far_edge(box_a.x, box_a.w);
        s1_d.a_b     = far_edge(box_a.y, box_a.h);
        s1_d.b_l     = {1'b0, box_b.x};
        s1_d.b_t     = {1'b0, box_b.y};
        s1_d.b_r     = far_edge(box_b.x, box_b.w);
        s1_d.b_b     = far_edge(box_b.y, box_b.h);
        // A degenerate box can still pass the edge compares, so gate it explicitly.
        s1_d.nonzero = (|box_a.w) && (|box_a.h) && (|box_b.w) && (|box_b.h);

        overlap_d = s1_q.nonzero
                 && (s1_q.a_l < s1_q.b_r) && (s1_q.b_l < s1_q.a_r)
                 && (s1_q.a_t < s1_q.b_b) && (s1_q.b_t < s1_q.a_b);

        if (clr) begin
            s1_d      = '0;
            overlap_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            overlap_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            overlap_q <= overlap_d;
        end
    end

endmodule

// File: rtl/collision_manager.sv
// Player/obstacle collision FSM: turns pipelined overlap into a tick-held
// collision strobe and tracks lives, hit count, grace period and game-over.
module collision_manager
    import collision_manager_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int GRACE_TICKS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               restart,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] player_w,
    input  logic [COORD_W-1:0] player_h,
    input  logic [COORD_W-1:0] obstacle_x_pos,
    input  logic [COORD_W-1:0] obstacle_y_pos,
    input  logic [COORD_W-1:0] obstacle_width,
    input  logic [COORD_W-1:0] obstacle_height,
    output logic               collision,
    output logic [2:0]         lives,
    output logic [7:0]         hit_count,
    output logic               invulnerable,
    output logic               game_over
);

    localparam logic [2:0] START_LIVES_V = 3'(START_LIVES);
    localparam logic [7:0] GRACE_V       = 8'(GRACE_TICKS);

    state_e     state_q, state_d;
    logic       collision_q, collision_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic [7:0] grace_cnt_q, grace_cnt_d;
    logic       invuln_q, invuln_d;
    logic       game_over_q, game_over_d;
    logic       pipe_clr;
    logic       overlap_q;
    box_t       player_box, obstacle_box;

    assign player_box   = '{x: player_x, y: player_y, w: player_w, h: player_h};
    assign obstacle_box = '{x: obstacle_x_pos, y: obstacle_y_pos,
                            w: obstacle_width, h: obstacle_height};

    bbox_overlap u_bbox_overlap (
        .clk       (clk),
        .rst       (rst),
        .clr       (pipe_clr),
        .box_a     (player_box),
        .box_b     (obstacle_box),
        .overlap_q (overlap_q)
    );

    always_comb begin
        state_d     = state_q;
        collision_d = collision_q;
        lives_d     = lives_q;
        hit_count_d = hit_count_q;
        grace_cnt_d = grace_cnt_q;
        invuln_d    = invuln_q;
        pipe_clr    = 1'b0;

        case (state_q)
            PLAYING: begin
                if (overlap_q) begin
                    state_d     = HIT;
                    collision_d = 1'b1;
                    lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    hit_count_d = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
                end
            end
            HIT: begin
                // The obstacle mover samples collision on game_en, so hold until one is seen.
                if (game_en) begin
                    collision_d = 1'b0;
                    if (lives_q == 3'd0) begin
                        state_d = GAME_OVER;
                    end else if (GRACE_TICKS == 0) begin
                        state_d = PLAYING;
                    end else begin
                        state_d     = INVULN;
                        grace_cnt_d = GRACE_V;
                        invuln_d    = 1'b1;
                    end
                end
            end
            INVULN: begin
                if (game_en) begin
                    if (grace_cnt_q <= 8'd1) begin
                        state_d     = PLAYING;
                        grace_cnt_d = 8'd0;
                        invuln_d    = 1'b0;
                    end else begin
                        grace_cnt_d = grace_cnt_q - 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                collision_d = 1'b0;
                if (restart) begin
                    state_d     = PLAYING;
                    lives_d     = START_LIVES_V;
                    hit_count_d = 8'd0;
                    pipe_clr    = 1'b1;
                end
            end
            default: state_d = PLAYING;
        endcase

        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLAYING;
            collision_q <= 1'b0;
            lives_q     <= START_LIVES_V;
            hit_count_q <= 8'd0;
            grace_cnt_q <= 8'd0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            collision_q <= collision_d;
            lives_q     <= lives_d;
            hit_count_q <= hit_count_d;
            grace_cnt_q <= grace_cnt_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign collision    = collision_q;
    assign lives        = lives_q;
    assign hit_count    = hit_count_q;
    assign invulnerable = invuln_q;
    assign game_over    = game_over_q;

endmodule
